pll_reset_seq: RTL and testbench
================================

# pll_reset_seq

Reset and lock supervisor for the on-chip PLL, running in the PLL reference clock domain. It drives the PLL `reset` input with a timed power-up pulse and waits for the PLL to settle. It then checks that the PLL output clock is alive by watching a heartbeat toggle generated in the `clk0_out` domain. It releases the system reset only after the heartbeat is verified, and it re-arms the PLL on loss of heartbeat, with a bounded retry count and a sticky fault flag.

## Interface
Parameters:
- `RST_CYCLES`, 32: `refclk` cycles `pll_reset` stays high after `reset_n` release.
- `SETTLE_CYCLES`, 5000: `refclk` cycles waited after `pll_reset` falls before checking starts.
- `HB_TIMEOUT`, 256: maximum `refclk` cycles allowed between heartbeat edges.
- `HB_MIN_EDGES`, 4: consecutive in-time heartbeat edges required before release.
- `MAX_RETRY`, 3: PLL re-reset attempts before entering FAULT.

Ports:
- `refclk` in 1: the only clock, the 50 MHz reference.
- `reset_n` in 1: synchronous, active-low reset.
- `hb_async` in 1: heartbeat toggle from the `clk0_out` domain, asynchronous to `refclk`.
  - Its toggle period must be ≤ `HB_TIMEOUT`/4 `refclk` cycles.
- `restart` in 1: single-cycle pulse that clears retries and restarts the sequence.
- `pll_reset` out 1: drives the PLL reset input, active high.
- `sys_rst_n` out 1: system reset for `clk0_out`/`clk1_out` logic, active low.
  - Downstream re-synchronizes it.
- `ready` out 1: PLL verified and system released.
- `fault` out 1: retries exhausted; sticky.
- `retry_cnt` out `$clog2(MAX_RETRY+1)`: retries consumed since the last reset or restart.

## Operation
- Heartbeat path: `hb_async` passes through a 2-FF synchronizer, then a third register. An edge is detected when stage 2 XOR stage 3 is 1.
- States: RESET, SETTLE, CHECK, RUN, FAULT. One shared cycle counter, cleared on every state entry.
- RESET:
  - `pll_reset`=1, `sys_rst_n`=0, `ready`=0.
  - Moves to SETTLE once the counter reaches `RST_CYCLES`-1.
- SETTLE:
  - `pll_reset`=0.
  - Heartbeat edges are ignored.
  - Moves to CHECK once the counter reaches `SETTLE_CYCLES`-1.
- CHECK:
  - Each edge clears the timeout counter and increments the edge count.
  - Reaching `HB_MIN_EDGES` edges moves to RUN.
  - A timeout is the counter reaching `HB_TIMEOUT`-1 with no edge. On timeout:
    - if `retry_cnt` < `MAX_RETRY`: `retry_cnt`++ and go to RESET;
    - otherwise go to FAULT.
- RUN:
  - `sys_rst_n`=1, `ready`=1.
  - Each edge clears the timeout counter.
  - A timeout takes the same retry/FAULT path as in CHECK.
- FAULT:
  - `pll_reset`=1, `sys_rst_n`=0, `ready`=0, `fault`=1.
  - Exits only via `reset_n` or `restart`.
- `restart`, in any state: go to RESET, `retry_cnt`=0, `fault`=0.
- Priority: `reset_n` > `restart` > edge > timeout. An edge in the same cycle as the timeout threshold counts as in-time.
- `retry_cnt` saturates at `MAX_RETRY`. A successful RUN entry does not clear it.

## Timing
- All outputs are registered and decoded from the registered state.
- Values while `reset_n`=0, and in the first cycle after release: `pll_reset`=1, `sys_rst_n`=0, `ready`=0, `fault`=0, `retry_cnt`=0, state RESET, counters 0.
- After `reset_n` rises, `pll_reset` stays 1 for exactly `RST_CYCLES` clock edges.
- Heartbeat latency: a `hb_async` transition is seen as an edge 2–3 `refclk` cycles later.
- `ready` and `sys_rst_n` rise together, 1 cycle after the `HB_MIN_EDGES`-th detected edge.
- On a timeout or `restart` from RUN:
  - `sys_rst_n` and `ready` fall, and `pll_reset` rises, in the same cycle;
  - there is no cycle with `ready`=1 and `pll_reset`=1.
- If `reset_n` is asserted mid-sequence, the block returns to reset values at the next `refclk` edge, regardless of state.

## Structure
- Shared package `pll_seq_pkg` holds:
  - the state enum `pll_seq_state_t`;
  - default parameter constants;
  - the counter width function, sized for max(`SETTLE_CYCLES`, `HB_TIMEOUT`, `RST_CYCLES`).
- One sub-module, `sync_edge_det`: the 2-FF synchronizer plus edge register, outputting a single-cycle `edge` strobe.
- The FSM and counters live in `pll_reset_seq`.

## Test plan
All scenarios use `RST_CYCLES`=4, `SETTLE_CYCLES`=8, `HB_TIMEOUT`=16, `HB_MIN_EDGES`=4, `MAX_RETRY`=2.

- Nominal power-up, `hb_async` toggling every 4 cycles -> `pll_reset` high for 4 cycles after release, then 8 settle cycles. `ready`=`sys_rst_n`=1 one cycle after the 4th detected edge; `retry_cnt`=0.
- `hb_async` held constant -> three `pll_reset` pulses in total (initial plus 2 retries), then `fault`=1, `retry_cnt`=2, `pll_reset`=1 held, `ready`=0.
- In RUN, stop toggling -> 16 cycles after the last edge: `ready`=0, `sys_rst_n`=0, `pll_reset`=1, `retry_cnt`=1. Resuming toggles returns the block to RUN.
- In FAULT, pulse `restart` -> `fault`=0, `retry_cnt`=0, and a fresh 4-cycle `pll_reset` pulse.
- `reset_n`=0 asserted mid-SETTLE -> next edge gives `pll_reset`=1, `sys_rst_n`=0, `ready`=0, `retry_cnt`=0.
- Edge detected exactly at counter value 15 -> no timeout, no retry. An edge one cycle later -> timeout, `retry_cnt` increments.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL reset/lock supervisor.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_SETTLE,
    ST_CHECK,
    ST_RUN,
    ST_FAULT
  } pll_seq_state_t;

  localparam int DEF_RST_CYCLES    = 32;
  localparam int DEF_SETTLE_CYCLES = 5000;
  localparam int DEF_HB_TIMEOUT    = 256;
  localparam int DEF_HB_MIN_EDGES  = 4;
  localparam int DEF_MAX_RETRY     = 3;

  // Width of the shared cycle counter; it only ever counts up to (longest interval - 1).
  function automatic int cnt_width(input int rst_cycles, input int settle_cycles,
                                   input int hb_timeout);
    int m;
    m = rst_cycles;
    if (settle_cycles > m) m = settle_cycles;
    if (hb_timeout > m) m = hb_timeout;
    if (m < 2) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for the heartbeat toggle plus an edge register.
// edge_strb is high for one cycle whenever the synchronized level changes.
module sync_edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic edge_strb
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  // Next-state of the shift chain: async input into stage 1, then shift along.
  always_comb begin
    s1_d = async_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Synchronizer and edge flops, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign edge_strb = s2_q ^ s3_q;

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset and lock supervisor: times the PLL reset pulse, waits for settling,
// verifies the output-clock heartbeat and releases the system reset, re-arming
// the PLL on heartbeat loss with a bounded number of retries.
module pll_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int HB_TIMEOUT    = DEF_HB_TIMEOUT,
  parameter int HB_MIN_EDGES  = DEF_HB_MIN_EDGES,
  parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
  input  logic                           refclk,
  input  logic                           reset_n,
  input  logic                           hb_async,
  input  logic                           restart,
  output logic                           pll_reset,
  output logic                           sys_rst_n,
  output logic                           ready,
  output logic                           fault,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);

  localparam int CNT_W   = cnt_width(RST_CYCLES, SETTLE_CYCLES, HB_TIMEOUT);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam int EDGE_W  = (HB_MIN_EDGES < 2) ? 1 : $clog2(HB_MIN_EDGES);

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(HB_TIMEOUT - 1);
  localparam logic [EDGE_W-1:0]  EDGE_LAST   = EDGE_W'(HB_MIN_EDGES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

  pll_seq_state_t     state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [EDGE_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               pll_reset_q, pll_reset_d;
  logic               sys_rst_n_q, sys_rst_n_d;
  logic               ready_q, ready_d;
  logic               fault_q, fault_d;
  logic               hb_edge;
  logic               retry_req;

  sync_edge_det u_sync (
    .clk       (refclk),
    .reset_n   (reset_n),
    .async_in  (hb_async),
    .edge_strb (hb_edge)
  );

  // Sequencer next state: restart beats edges, edges beat timeouts, and the
  // counter is cleared on every state entry.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_cnt_d = edge_cnt_q;
    retry_d    = retry_q;
    retry_req  = 1'b0;

    if (restart) begin
      state_d    = ST_RESET;
      cnt_d      = '0;
      edge_cnt_d = '0;
      retry_d    = '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_SETTLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d    = ST_CHECK;
            cnt_d      = '0;
            edge_cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_CHECK: begin
          if (hb_edge) begin
            cnt_d = '0;
            if (edge_cnt_q == EDGE_LAST) begin
              state_d    = ST_RUN;
              edge_cnt_d = '0;
            end else begin
              edge_cnt_d = edge_cnt_q + 1'b1;
            end
          end else if (cnt_q == TO_LAST) begin
            retry_req = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (hb_edge) begin
            cnt_d = '0;
          end else if (cnt_q == TO_LAST) begin
            retry_req = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_FAULT: begin
          cnt_d = '0;
        end
        default: begin
          state_d = ST_RESET;
          cnt_d   = '0;
        end
      endcase

      if (retry_req) begin
        cnt_d      = '0;
        edge_cnt_d = '0;
        if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + 1'b1;
          state_d = ST_RESET;
        end else begin
          state_d = ST_FAULT;
        end
      end
    end

    pll_reset_d = (state_d == ST_RESET) || (state_d == ST_FAULT);
    sys_rst_n_d = (state_d == ST_RUN);
    ready_d     = (state_d == ST_RUN);
    fault_d     = (state_d == ST_FAULT);
  end

  // State, counters and outputs register together so the outputs always match the state.
  always_ff @(posedge refclk) begin
    if (!reset_n) begin
      state_q     <= ST_RESET;
      cnt_q       <= '0;
      edge_cnt_q  <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  assign pll_reset = pll_reset_q;
  assign sys_rst_n = sys_rst_n_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with a small scoreboard of expected values.
module tb_pll_reset_seq;

  localparam int RST_C = 4;
  localparam int SET_C = 8;
  localparam int TO_C  = 16;
  localparam int MIN_E = 4;
  localparam int MAX_R = 2;

  logic       refclk = 1'b0;
  logic       reset_n;
  logic       hb_async;
  logic       restart;
  logic       pll_reset;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [1:0] retry_cnt;

  typedef struct {
    string tag;
    int    value;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  pll_reset_seq #(
    .RST_CYCLES    (RST_C),
    .SETTLE_CYCLES (SET_C),
    .HB_TIMEOUT    (TO_C),
    .HB_MIN_EDGES  (MIN_E),
    .MAX_RETRY     (MAX_R)
  ) dut (
    .refclk    (refclk),
    .reset_n   (reset_n),
    .hb_async  (hb_async),
    .restart   (restart),
    .pll_reset (pll_reset),
    .sys_rst_n (sys_rst_n),
    .ready     (ready),
    .fault     (fault),
    .retry_cnt (retry_cnt)
  );

  // 10 ns reference clock
  always #5 refclk = ~refclk;

  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic applyStimulus(input logic rn, input logic rs);
    reset_n = rn;
    restart = rs;
  endtask

  task automatic toggleHb();
    hb_async = ~hb_async;
  endtask

  function automatic int outVec();
    return {26'd0, pll_reset, sys_rst_n, ready, fault, retry_cnt};
  endfunction

  function automatic int mkVec(input bit pr, input bit sr, input bit rd, input bit ft,
                               input int rc);
    logic [1:0] r;
    r = rc[1:0];
    return {26'd0, pr, sr, rd, ft, r};
  endfunction

  task automatic pushExp(input string tag, input int value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input int observed);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("[TB] FAIL scoreboard_empty: observed=%0h expected=<none>", observed);
    end else begin
      e = exp_q.pop_front();
      assert (observed === e.value) else begin
        errors++;
        $error("[TB] FAIL %s: observed=%0h expected=%0h", e.tag, observed, e.value);
      end
    end
  endtask

  // Counts clock cycles while pll_reset holds lvl, bounded so a stuck DUT still ends.
  task automatic countWhile(input logic lvl, output int n);
    n = 0;
    while (pll_reset === lvl && n < 200) begin
      step(1);
      n++;
    end
  endtask

  initial begin
    int n;
    hb_async = 1'b0;
    applyStimulus(1'b0, 1'b0);
    step(3);
    pushExp("reset_vals", mkVec(1, 0, 0, 0, 0));
    checkOutput(outVec());

    applyStimulus(1'b1, 1'b0);
    pushExp("release_vals", mkVec(1, 0, 0, 0, 0));
    checkOutput(outVec());

    // Heartbeat held constant: three reset pulses, each followed by settle+timeout.
    for (int i = 0; i < 3; i++) begin
      pushExp($sformatf("pulse%0d_high", i), RST_C);
      countWhile(1'b1, n);
      checkOutput(n);
      pushExp($sformatf("pulse%0d_low_vals", i), mkVec(0, 0, 0, 0, i));
      checkOutput(outVec());
      pushExp($sformatf("pulse%0d_low_len", i), SET_C + TO_C);
      countWhile(1'b0, n);
      checkOutput(n);
    end
    pushExp("fault_vals", mkVec(1, 0, 0, 1, 2));
    checkOutput(outVec());
    step(40);
    pushExp("fault_hold", mkVec(1, 0, 0, 1, 2));
    checkOutput(outVec());

    // Restart out of FAULT.
    applyStimulus(1'b1, 1'b1);
    step(1);
    applyStimulus(1'b1, 1'b0);
    pushExp("restart_vals", mkVec(1, 0, 0, 0, 0));
    checkOutput(outVec());
    pushExp("restart_pulse", RST_C);
    countWhile(1'b1, n);
    checkOutput(n);

    // Nominal lock: CHECK starts after the settle window, toggle every 4 cycles.
    step(SET_C);
    repeat (3) begin
      toggleHb();
      step(4);
    end
    toggleHb();
    step(2);
    pushExp("pre_ready", mkVec(0, 0, 0, 0, 0));
    checkOutput(outVec());
    step(1);
    pushExp("ready_vals", mkVec(0, 1, 1, 0, 0));
    checkOutput(outVec());

    // Keep toggling in RUN, then stop: timeout 16 cycles after the last detected edge.
    step(1);
    repeat (5) begin
      toggleHb();
      step(4);
    end
    pushExp("run_hold", mkVec(0, 1, 1, 0, 0));
    checkOutput(outVec());
    step(14);
    pushExp("before_timeout", mkVec(0, 1, 1, 0, 0));
    checkOutput(outVec());
    step(1);
    pushExp("hb_loss", mkVec(1, 0, 0, 0, 1));
    checkOutput(outVec());

    // Resume toggles: back to RUN with retry count kept.
    pushExp("rearm_pulse", RST_C);
    countWhile(1'b1, n);
    checkOutput(n);
    step(SET_C);
    repeat (3) begin
      toggleHb();
      step(4);
    end
    toggleHb();
    step(2);
    pushExp("rearm_pre_ready", mkVec(0, 0, 0, 0, 1));
    checkOutput(outVec());
    step(1);
    pushExp("rearm_ready", mkVec(0, 1, 1, 0, 1));
    checkOutput(outVec());

    // Boundary: edge at counter value 15 is in time, one cycle later is a timeout.
    step(1);
    toggleHb();
    step(16);
    toggleHb();
    step(4);
    pushExp("gap16_in_time", mkVec(0, 1, 1, 0, 1));
    checkOutput(outVec());
    step(13);
    toggleHb();
    step(2);
    pushExp("gap17_timeout", mkVec(1, 0, 0, 0, 2));
    checkOutput(outVec());

    // reset_n asserted in the middle of SETTLE.
    pushExp("pre_settle_pulse", RST_C);
    countWhile(1'b1, n);
    checkOutput(n);
    step(3);
    applyStimulus(1'b0, 1'b0);
    step(1);
    pushExp("midsettle_reset", mkVec(1, 0, 0, 0, 0));
    checkOutput(outVec());
    applyStimulus(1'b1, 1'b0);
    step(1);
    pushExp("post_release", mkVec(1, 0, 0, 0, 0));
    checkOutput(outVec());
    pushExp("post_release_pulse", RST_C - 1);
    countWhile(1'b1, n);
    checkOutput(n);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
